// File: rtl/seq_scheduler_pkg.sv
// Shared types and default sizing for the step-sequence scheduler.
package seq_pkg;

    localparam int DEPTH_DEF  = 8;   // step-table entries
    localparam int PAT_W_DEF  = 8;   // output pattern width
    localparam int TIME_W_DEF = 20;  // step duration width (us)

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        FIN
    } state_e;

endpackage

// File: rtl/seq_scheduler_if.sv
// Timer handshake: the scheduler (master) loads a one-shot duration and
// enables the timer; the timer (slave) answers with a done pulse.
interface tmr_if #(
    parameter int TIME_W = seq_pkg::TIME_W_DEF
);
    logic              clear;
    logic              enable;
    logic              mode;
    logic [TIME_W-1:0] time_count;
    logic              done;

    modport master (output clear, enable, mode, time_count, input done);
    modport slave  (input clear, enable, mode, time_count, output done);
endinterface

// File: rtl/seq_scheduler_table.sv
// Step table: DEPTH x W register file, one synchronous write port and one
// combinational read port.
module seq_table #(
    parameter int DEPTH = seq_pkg::DEPTH_DEF,
    parameter int W     = seq_pkg::TIME_W_DEF + seq_pkg::PAT_W_DEF
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port.
    // NOTE: storage arrays carry no reset; contents stay undefined until
    // written, which keeps this a plain register file without a reset tree.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/seq_scheduler.sv
// Step-sequence scheduler: walks a table of {duration, pattern} steps,
// timing each one through an external one-shot timer.
// Optional macro SEQ_SCHEDULER_LOOP_EN adds a loop_en input that repeats
// the sequence from step 0 until stopped.
module seq_scheduler
    import seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PAT_W  = PAT_W_DEF,
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [TIME_W-1:0]        wr_time,
    input  logic [PAT_W-1:0]         wr_pat,
    input  logic [$clog2(DEPTH)-1:0] last_idx,
    input  logic                     start,
    input  logic                     stop,
    output logic [PAT_W-1:0]         pattern,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     busy,
    output logic                     step_pulse,
    output logic                     seq_done,
`ifdef SEQ_SCHEDULER_LOOP_EN
    input  logic                     loop_en,
`endif
    tmr_if.master                    tmr
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = TIME_W + PAT_W;

    state_e          state_q, state_d;
    logic [AW-1:0]   step_idx_q, step_idx_d;
    logic [AW-1:0]   last_q, last_d;
    logic            step_pulse_q, step_pulse_d;
    logic            seq_done_q, seq_done_d;
    logic            abort_q, abort_d;   // one-cycle timer clear after stop
    logic [ENT_W-1:0] rd_data;
    logic [TIME_W-1:0] rd_time;
    logic [PAT_W-1:0]  rd_pat;
    logic            loop_now;

`ifdef SEQ_SCHEDULER_LOOP_EN
    assign loop_now = loop_en;
`else
    assign loop_now = 1'b0;
`endif

    // Table is writable only while idle so a running sequence never changes.
    seq_table #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_table (
        .clk     (clk),
        .we_i    (wr_en && (state_q == IDLE)),
        .waddr_i (wr_addr),
        .wdata_i ({wr_time, wr_pat}),
        .raddr_i (step_idx_q),
        .rdata_o (rd_data)
    );

    assign rd_time = rd_data[ENT_W-1 -: TIME_W];
    assign rd_pat  = rd_data[PAT_W-1:0];

    // State and control registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            step_idx_q   <= '0;
            last_q       <= '0;
            step_pulse_q <= 1'b0;
            seq_done_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_idx_q   <= step_idx_d;
            last_q       <= last_d;
            step_pulse_q <= step_pulse_d;
            seq_done_q   <= seq_done_d;
            abort_q      <= abort_d;
        end
    end

    // Next-state logic; stop wins over everything, including a start
    // arriving in the same cycle.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        step_idx_d   = step_idx_q;
        last_d       = last_q;
        step_pulse_d = 1'b0;
        seq_done_d   = 1'b0;
        abort_d      = 1'b0;
        if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        last_d     = last_idx;
                        step_idx_d = '0;
                        state_d    = ARM;
                    end
                end
                ARM:  state_d = RUN;
                RUN: begin
                    if (tmr.done) begin
                        step_pulse_d = 1'b1;
                        if (step_idx_q != last_q) begin
                            step_idx_d = step_idx_q + 1'b1;
                            state_d    = ARM;
                        end else if (loop_now) begin
                            step_idx_d = '0;
                            seq_done_d = 1'b1;
                            state_d    = ARM;
                        end else begin
                            seq_done_d = 1'b1;
                            state_d    = FIN;
                        end
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state, so reset forces them at once.
    always_comb begin
        busy           = (state_q != IDLE);
        pattern        = ((state_q == ARM) || (state_q == RUN)) ? rd_pat : '0;
        tmr.clear      = (state_q == ARM) || abort_q;
        tmr.enable     = (state_q == RUN);
        tmr.mode       = 1'b0;
        tmr.time_count = (state_q == RUN) ? rd_time : '0;
    end

    assign step_idx   = step_idx_q;
    assign step_pulse = step_pulse_q;
    assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_seq_scheduler.sv
// Directed bench for seq_scheduler with a behavioural one-shot timer.
module tb_seq_scheduler;
    import seq_pkg::*;

    localparam int DEPTH  = 8;
    localparam int PAT_W  = 8;
    localparam int TIME_W = 20;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [TIME_W-1:0] wr_time;
    logic [PAT_W-1:0]  wr_pat;
    logic [AW-1:0]     last_idx;
    logic              start, stop;
    logic [PAT_W-1:0]  pattern;
    logic [AW-1:0]     step_idx;
    logic              busy, step_pulse, seq_done;
    logic              loop_en;
    logic              inj_done;
    logic              model_done;
    int unsigned       mcnt;

    tmr_if #(.TIME_W(TIME_W)) tmr_bus ();

    always #5 clk = ~clk;

    seq_scheduler #(.DEPTH(DEPTH), .PAT_W(PAT_W), .TIME_W(TIME_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_time    (wr_time),
        .wr_pat     (wr_pat),
        .last_idx   (last_idx),
        .start      (start),
        .stop       (stop),
        .pattern    (pattern),
        .step_idx   (step_idx),
        .busy       (busy),
        .step_pulse (step_pulse),
        .seq_done   (seq_done),
`ifdef SEQ_SCHEDULER_LOOP_EN
        .loop_en    (loop_en),
`endif
        .tmr        (tmr_bus)
    );

    // One-shot timer model, 1 cycle per us; a duration of 0 acts as 1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt       <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (tmr_bus.clear || !tmr_bus.enable) begin
                mcnt <= 0;
            end else begin
                mcnt <= mcnt + 1;
                if (mcnt + 1 == ((tmr_bus.time_count == 0) ? 1 : int'(tmr_bus.time_count)))
                    model_done <= 1'b1;
            end
        end
    end
    assign tmr_bus.done = model_done | inj_done;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observations from one watched run.
    int               w_end, w_done_cyc, w_first_en;
    int               n_pulse, n_done, n_clear, n_steps;
    logic             w_timeout;
    logic [PAT_W-1:0] obs_pat  [16];
    logic [TIME_W-1:0] obs_time [16];
    int               obs_idx  [16];

    task automatic write_entry(input int addr, input int t, input int p);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_time = TIME_W'(t);
        wr_pat  = PAT_W'(p);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic start_run(input int last);
        @(negedge clk);
        last_idx = AW'(last);
        start    = 1'b1;
    endtask

    // Cycle 0 is the start cycle; watches until busy falls or budget ends.
    task automatic watch(input int wr_at, input int stop_at, input int budget);
        logic prev_en;
        prev_en = 1'b0;
        n_pulse = 0; n_done = 0; n_clear = 0; n_steps = 0;
        w_timeout = 1'b1; w_done_cyc = -1; w_first_en = -1; w_end = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0; wr_en = 1'b0;
            if (tmr_bus.enable && !prev_en) begin
                if (n_steps < 16) begin
                    obs_pat[n_steps]  = pattern;
                    obs_time[n_steps] = tmr_bus.time_count;
                    obs_idx[n_steps]  = int'(step_idx);
                end
                if (w_first_en < 0) w_first_en = c;
                n_steps++;
            end
            prev_en = tmr_bus.enable;
            if (tmr_bus.clear) n_clear++;
            if (step_pulse)    n_pulse++;
            if (seq_done) begin
                n_done++;
                w_done_cyc = c;
            end
            if (!busy) begin
                w_end     = c;
                w_timeout = 1'b0;
                break;
            end
            if (c == wr_at) begin
                wr_en = 1'b1; wr_addr = '0; wr_time = 9; wr_pat = 8'h80;
            end
            if (c == stop_at) stop = 1'b1;
        end
        check("watch_timeout", 32'(w_timeout), 0);
    endtask

    typedef struct {
        int last;
        int tim [4];
        int pat [4];
        int exp_cyc;    // start cycle -> seq_done cycle
        int exp_pulse;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Each step costs ARM(1) + RUN(max(t,1)+1); plus 1 for the start cycle.
        vecs[0] = '{last: 2, tim: '{5, 3, 2, 0}, pat: '{8'h01, 8'h02, 8'h04, 0}, exp_cyc: 17, exp_pulse: 3};
        vecs[1] = '{last: 0, tim: '{0, 0, 0, 0}, pat: '{8'hAA, 0, 0, 0},          exp_cyc: 4,  exp_pulse: 1};
        vecs[2] = '{last: 3, tim: '{1, 0, 2, 4}, pat: '{8'h11, 8'h22, 8'h33, 8'h44}, exp_cyc: 17, exp_pulse: 4};
        vecs[3] = '{last: 1, tim: '{1, 1, 0, 0}, pat: '{8'hFF, 8'h00, 0, 0},      exp_cyc: 7,  exp_pulse: 2};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_time = '0; wr_pat = '0;
        last_idx = '0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; inj_done = 1'b0;
        #12;
        check("rst_busy",     32'(busy), 0);
        check("rst_pattern",  32'(pattern), 0);
        check("rst_step_idx", 32'(step_idx), 0);
        check("rst_clear",    32'(tmr_bus.clear), 0);
        check("rst_enable",   32'(tmr_bus.enable), 0);
        check("rst_time",     32'(tmr_bus.time_count), 0);
        check("rst_pulses",   32'({step_pulse, seq_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single-shot sequences.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i <= vecs[v].last; i++)
                write_entry(i, vecs[v].tim[i], vecs[v].pat[i]);
            start_run(vecs[v].last);
            watch(-1, -1, 200);
            check($sformatf("v%0d_first_enable", v), 32'(w_first_en), 2);
            check($sformatf("v%0d_done_cycle", v),   32'(w_done_cyc), 32'(vecs[v].exp_cyc));
            check($sformatf("v%0d_busy_drop", v),    32'(w_end), 32'(vecs[v].exp_cyc + 1));
            check($sformatf("v%0d_step_pulses", v),  32'(n_pulse), 32'(vecs[v].exp_pulse));
            check($sformatf("v%0d_seq_done", v),     32'(n_done), 1);
            check($sformatf("v%0d_clears", v),       32'(n_clear), 32'(vecs[v].last + 1));
            check($sformatf("v%0d_steps", v),        32'(n_steps), 32'(vecs[v].last + 1));
            for (int i = 0; i <= vecs[v].last; i++) begin
                check($sformatf("v%0d_s%0d_pattern", v, i), 32'(obs_pat[i]), 32'(vecs[v].pat[i]));
                check($sformatf("v%0d_s%0d_time", v, i),    32'(obs_time[i]), 32'(vecs[v].tim[i]));
                check($sformatf("v%0d_s%0d_idx", v, i),     32'(obs_idx[i]), 32'(i));
            end
            check($sformatf("v%0d_idle_pattern", v), 32'(pattern), 0);
        end
        check("mode_oneshot", 32'(tmr_bus.mode), 0);

        // Write while busy is ignored.
        write_entry(0, 5, 8'h01); write_entry(1, 3, 8'h02); write_entry(2, 2, 8'h04);
        start_run(2);
        watch(1, -1, 200);
        check("busywr_time0", 32'(obs_time[0]), 5);
        start_run(2);
        watch(-1, -1, 200);
        check("busywr_rerun_time0", 32'(obs_time[0]), 5);
        check("busywr_rerun_pat0",  32'(obs_pat[0]), 8'h01);

        // Stop in the first RUN cycle of step 1 (cycle 9).
        start_run(2);
        watch(-1, 9, 200);
        check("stop_idle_cycle", 32'(w_end), 10);
        check("stop_pattern",    32'(pattern), 0);
        check("stop_clear",      32'(tmr_bus.clear), 1);
        check("stop_enable",     32'(tmr_bus.enable), 0);
        check("stop_no_done",    32'(n_done), 0);
        check("stop_pulses",     32'(n_pulse), 1);
        @(negedge clk);
        check("stop_clear_one_cycle", 32'(tmr_bus.clear), 0);
        check("stop_quiet", 32'({step_pulse, seq_done, busy}), 0);

        // Simultaneous start and stop in IDLE.
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy",  32'(busy), 0);
        check("startstop_clear", 32'(tmr_bus.clear), 0);

        // Timer done outside RUN is ignored.
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        check("idle_done_pulse", 32'(step_pulse), 0);
        check("idle_done_busy",  32'(busy), 0);

        // Async reset while running step 1.
        start_run(2);
        begin
            logic found;
            found = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (tmr_bus.enable && step_idx == 1) begin
                    found = 1'b1;
                    break;
                end
            end
            check("arst_reached_step1", 32'(found), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",     32'(busy), 0);
        check("arst_pattern",  32'(pattern), 0);
        check("arst_step_idx", 32'(step_idx), 0);
        check("arst_clear",    32'(tmr_bus.clear), 0);
        check("arst_enable",   32'(tmr_bus.enable), 0);
        check("arst_time",     32'(tmr_bus.time_count), 0);
        check("arst_pulses",   32'({step_pulse, seq_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run(2);
        watch(-1, -1, 200);
        check("arst_rerun_done_cycle", 32'(w_done_cyc), 17);

`ifdef SEQ_SCHEDULER_LOOP_EN
        // Looping: step 0 = 3 cycles, step 1 = 4 cycles; stop at cycle 30.
        write_entry(0, 1, 8'h10); write_entry(1, 2, 8'h20);
        loop_en = 1'b1;
        start_run(1);
        watch(-1, 30, 200);
        loop_en = 1'b0;
        check("loop_end_cycle", 32'(w_end), 31);
        check("loop_seq_dones", 32'(n_done), 4);
        check("loop_pulses",    32'(n_pulse), 8);
        check("loop_steps",     32'(n_steps), 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("loop_idx%0d", i), 32'(obs_idx[i]), 32'(i % 2));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_scheduler.md
SEQ_SCHEDULER -- requirements
Module: seq_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of step-table entries (power of 2, 2..16).
REQ-002 SHALL have parameter PAT_W, default 8, meaning width of the per-step output pattern.
REQ-003 SHALL have parameter TIME_W, default 20, meaning width of the per-step duration in µs; it matches tmr_if.time_count.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  table write strobe.
REQ-007 SHALL have port wr_addr  input  $clog2(DEPTH)  table write index.
REQ-008 SHALL have port wr_time  input  TIME_W  step duration in µs.
REQ-009 SHALL have port wr_pat  input  PAT_W  step output pattern.
REQ-010 SHALL have port last_idx  input  $clog2(DEPTH)  index of the final step, sampled on start.
REQ-011 SHALL have ports start and stop, each input, 1 bit, single-cycle command pulses.
REQ-012 SHALL have port pattern  output  PAT_W  pattern of the active step.
REQ-013 SHALL have port step_idx  output  $clog2(DEPTH)  index of the active step.
REQ-014 SHALL have ports busy, step_pulse and seq_done, each output, 1 bit: busy flag, end-of-step pulse, end-of-sequence pulse.
REQ-015 SHALL have port tmr, a tmr_if controller side: drives clear, enable, mode and time_count; receives done.

Function
REQ-016 SHALL write table[wr_addr] <= {wr_time, wr_pat} on wr_en only while in IDLE; writes in other states are ignored.
REQ-017 SHALL implement FSM states IDLE, ARM, RUN, FIN.
REQ-018 SHALL, in IDLE on start, latch last_idx, set step_idx=0 and go to ARM on the next cycle.
REQ-019 SHALL, in ARM, hold tmr.clear=1 and tmr.enable=0 and drive pattern=table[step_idx].pat; it goes to RUN after exactly 1 cycle.
REQ-020 SHALL, in RUN, hold tmr.enable=1, tmr.clear=0, tmr.mode=0 (one-shot) and tmr.time_count=table[step_idx].time, stable for the whole step.
REQ-021 SHALL, in RUN on tmr.done=1, pulse step_pulse for 1 cycle.
REQ-022 SHALL then increment step_idx and go to ARM if step_idx != latched last_idx, else go to FIN.
REQ-023 SHALL, in FIN, pulse seq_done for 1 cycle, drive pattern=0 and tmr.enable=0, and go to IDLE next cycle.
REQ-024 SHALL drive busy=1 in ARM, RUN and FIN, and busy=0 in IDLE.
REQ-025 SHALL, on stop in any non-IDLE state, go to IDLE next cycle with pattern=0, tmr.clear=1 for that one cycle, and no step_pulse or seq_done.
REQ-026 SHALL give stop priority when start and stop arrive together; start while busy is ignored.
REQ-027 SHALL ignore tmr.done outside RUN.
REQ-028 SHALL pass a duration of 0 through unchanged, so the timer yields its minimum (1 µs) step.
REQ-029 SHALL have latency start->first tmr.enable=1 of 2 cycles, and tmr.done->next-step tmr.enable of 2 cycles.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force: state=IDLE, step_idx=0, pattern=0, busy=0, step_pulse=0, seq_done=0, tmr.clear=0, tmr.enable=0, tmr.mode=0, tmr.time_count=0.
REQ-031 SHALL leave table contents unreset (undefined until written); reset mid-sequence abandons the run without pulses.

Configuration
REQ-032 SHALL, with macro SEQ_SCHEDULER_LOOP_EN defined, add input port loop_en (1 bit).
REQ-033 SHALL, when loop_en=1 at the last step's done, pulse seq_done and return to ARM with step_idx=0 instead of FIN, repeating until stop.
REQ-034 SHALL, without SEQ_SCHEDULER_LOOP_EN, have no loop_en port and always run the sequence once.

Structure
REQ-035 SHALL place the state enum (IDLE, ARM, RUN, FIN) and default DEPTH/PAT_W/TIME_W constants in package seq_pkg.
REQ-036 SHALL implement the step table as sub-module seq_table: a DEPTH x (TIME_W+PAT_W) register file, one synchronous write port and one combinational read port.

Verification
REQ-037 SHALL verify single sequence: table {5µs,0x01},{3µs,0x02},{2µs,0x04}, last_idx=2, start -> pattern 01,02,04 in order; 3 step_pulse; 1 seq_done; busy drops 1 cycle after seq_done.
REQ-038 SHALL verify timer handshake: each step shows tmr.clear=1 for 1 cycle, then enable=1 with time_count=5,3,2; enable 2 cycles after start.
REQ-039 SHALL verify stop during step 1 of REQ-037 -> IDLE next cycle, pattern=0, clear=1 one cycle, no seq_done.
REQ-040 SHALL verify write during busy to addr 0 with time 9 -> ignored; rerun shows time_count=5.
REQ-041 SHALL verify simultaneous start+stop in IDLE -> remains IDLE, busy=0; and async reset in RUN -> all outputs at reset values immediately.
REQ-042 SHALL verify, with SEQ_SCHEDULER_LOOP_EN and loop_en=1, last_idx=1: seq_done at each wrap, step_idx 0,1,0,1,... until stop.
